main_controller: RTL and testbench

//  Multicycle MIPS main control FSM. It decodes the 6-bit opcode from the instruction

---
 rtl/main_controller.sv | 186 ++++++++++++++++++
 tb/tb_main_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/main_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// from the opcode and guards every memory wait with a watchdog counter.
module main_controller #(
    parameter logic [2:0] ALUOP_ADD   = 3'b000,
    parameter logic [2:0] ALUOP_SUB   = 3'b001,
    parameter logic [2:0] ALUOP_FUNCT = 3'b010,
    parameter int         TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WDOG_LIMIT = CW'(TIMEOUT - 1);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] wdog_reg, wdog_next;
    logic          is_sw_reg, is_sw_next;

    // Raw enables before the reset gate.
    logic irwrite_c, pcwrite_c, branch_c, memwrite_c, regwrite_c;
    logic waiting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            wdog_reg  <= '0;
            is_sw_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            wdog_reg  <= wdog_next;
            is_sw_reg <= is_sw_next;
        end
    end

    always_comb begin
        state_next  = S_FETCH;
        wdog_next   = '0;
        is_sw_next  = is_sw_reg;
        waiting     = 1'b0;
        irwrite_c   = 1'b0;
        pcwrite_c   = 1'b0;
        branch_c    = 1'b0;
        memwrite_c  = 1'b0;
        regwrite_c  = 1'b0;
        iord        = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = ALUOP_ADD;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;

        case (state_reg)
            S_FETCH: begin
                alusrcb    = 2'b01;
                irwrite_c  = mem_ready;
                pcwrite_c  = mem_ready;
                waiting    = 1'b1;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                is_sw_next = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = is_sw_reg ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                waiting    = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
                waiting    = 1'b1;
                state_next = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
            end
            S_BEQ: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = 2'b01;
                branch_c = 1'b1;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: regwrite_c = 1'b1;
            S_JUMP: begin
                pcsrc     = 2'b10;
                pcwrite_c = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        // Ready in the limit cycle wins; otherwise the abort suppresses the pending write.
        if (waiting && !mem_ready) begin
            if (wdog_reg == WDOG_LIMIT) begin
                mem_timeout = 1'b1;
                memwrite_c  = 1'b0;
                state_next  = S_FETCH;
            end else begin
                wdog_next = wdog_reg + 1'b1;
            end
        end
    end

    // Reset forces every write enable low without waiting for a clock edge.
    assign irwrite  = irwrite_c  & rst_n;
    assign pcwrite  = pcwrite_c  & rst_n;
    assign branch   = branch_c   & rst_n;
    assign memwrite = memwrite_c & rst_n;
    assign regwrite = regwrite_c & rst_n;
    assign state    = state_reg;

endmodule

// File: tb/tb_main_controller.sv
// Directed bench for main_controller: a cycle-by-cycle vector table for the
// instruction flows, plus hand sequences for watchdog and mid-instruction reset.
module tb_main_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluop;
    logic       illegal_op, mem_timeout;
    logic [3:0] state;

    always #5 clk = ~clk;

    main_controller #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
        .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
    );

    int checks = 0;
    int errors = 0;

    // en = {iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst, memtoreg, alusrca}
    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic [8:0] en;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       ill;
        logic       tmo;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [21:0] actual_word();
        return {iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, aluop, illegal_op, mem_timeout, state};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [8:0] en,
                       input logic [1:0] srcb, input logic [1:0] pcs, input logic [2:0] aop,
                       input logic ill, input logic tmo, input logic [3:0] st);
        vec_t v;
        v.op = op; v.rdy = rdy; v.en = en; v.srcb = srcb; v.pcsrc = pcs;
        v.aluop = aop; v.ill = ill; v.tmo = tmo; v.st = st;
        vecs.push_back(v);
    endtask

    // Apply inputs just after a rising edge and look at outputs on the falling edge.
    task automatic drive(input logic [5:0] op, input logic rdy);
        opcode    = op;
        mem_ready = rdy;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] X = 6'b111111;

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // FETCH + rdy
        add(X, 1, 9'b011000000, 2'b01, 2'b00, 3'b000, 0, 0, 4'd0);
        // lw
        add(6'b100011, 1, 9'b000000000, 2'b11, 2'b00, 3'b000, 0, 0, 4'd1);
        add(X, 1, 9'b000000001, 2'b10, 2'b00, 3'b000, 0, 0, 4'd2);
        add(X, 1, 9'b100000000, 2'b00, 2'b00, 3'b000, 0, 0, 4'd3);
        add(X, 1, 9'b000001010, 2'b00, 2'b00, 3'b000, 0, 0, 4'd4);
        // R-type
        add(X, 1, 9'b011000000, 2'b01, 2'b00, 3'b000, 0, 0, 4'd0);
        add(6'b000000, 1, 9'b000000000, 2'b11, 2'b00, 3'b000, 0, 0, 4'd1);
        add(X, 1, 9'b000000001, 2'b00, 2'b00, 3'b010, 0, 0, 4'd6);
        add(X, 1, 9'b000001100, 2'b00, 2'b00, 3'b000, 0, 0, 4'd7);
        // beq
        add(X, 1, 9'b011000000, 2'b01, 2'b00, 3'b000, 0, 0, 4'd0);
        add(6'b000100, 1, 9'b000000000, 2'b11, 2'b00, 3'b000, 0, 0, 4'd1);
        add(X, 1, 9'b000100001, 2'b00, 2'b01, 3'b001, 0, 0, 4'd8);
        // addi
        add(X, 1, 9'b011000000, 2'b01, 2'b00, 3'b000, 0, 0, 4'd0);
        add(6'b001000, 1, 9'b000000000, 2'b11, 2'b00, 3'b000, 0, 0, 4'd1);
        add(X, 1, 9'b000000001, 2'b10, 2'b00, 3'b000, 0, 0, 4'd9);
        add(X, 1, 9'b000001000, 2'b00, 2'b00, 3'b000, 0, 0, 4'd10);
        // j
        add(X, 1, 9'b011000000, 2'b01, 2'b00, 3'b000, 0, 0, 4'd0);
        add(6'b000010, 1, 9'b000000000, 2'b11, 2'b00, 3'b000, 0, 0, 4'd1);
        add(X, 1, 9'b001000000, 2'b00, 2'b10, 3'b000, 0, 0, 4'd11);
        // sw with three not-ready cycles
        add(X, 1, 9'b011000000, 2'b01, 2'b00, 3'b000, 0, 0, 4'd0);
        add(6'b101011, 1, 9'b000000000, 2'b11, 2'b00, 3'b000, 0, 0, 4'd1);
        add(X, 1, 9'b000000001, 2'b10, 2'b00, 3'b000, 0, 0, 4'd2);
        add(X, 0, 9'b100010000, 2'b00, 2'b00, 3'b000, 0, 0, 4'd5);
        add(X, 0, 9'b100010000, 2'b00, 2'b00, 3'b000, 0, 0, 4'd5);
        add(X, 0, 9'b100010000, 2'b00, 2'b00, 3'b000, 0, 0, 4'd5);
        add(X, 1, 9'b100010000, 2'b00, 2'b00, 3'b000, 0, 0, 4'd5);
        // illegal opcode
        add(X, 1, 9'b011000000, 2'b01, 2'b00, 3'b000, 0, 0, 4'd0);
        add(X, 1, 9'b000000000, 2'b11, 2'b00, 3'b000, 1, 0, 4'd1);
        add(X, 0, 9'b000000000, 2'b01, 2'b00, 3'b000, 0, 0, 4'd0);
        add(X, 1, 9'b011000000, 2'b01, 2'b00, 3'b000, 0, 0, 4'd0);

        // Reset state, with mem_ready high to show enables are held off.
        rst_n = 1'b0; opcode = X; mem_ready = 1'b1;
        #2;
        check("reset_outputs", 32'(actual_word()), 32'({9'b0, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 4'd0}));
        advance();
        advance();
        check("reset_hold", 32'(actual_word()), 32'({9'b0, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 4'd0}));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].rdy);
            check($sformatf("vec%0d", i), 32'(actual_word()),
                  32'({vecs[i].en, vecs[i].srcb, vecs[i].pcsrc, vecs[i].aluop,
                       vecs[i].ill, vecs[i].tmo, vecs[i].st}));
            advance();
        end

        // lw stuck in MEMRD: abort on the 16th waiting cycle.
        drive(6'b100011, 1); check("to_memadr_decode", 32'(state), 32'd1); advance();
        drive(X, 1);         check("memadr", 32'(state), 32'd2);          advance();
        for (int k = 1; k <= 15; k++) begin
            drive(X, 0);
            check($sformatf("memrd_wait%0d", k), 32'({mem_timeout, regwrite, state}), 32'({1'b0, 1'b0, 4'd3}));
            advance();
        end
        drive(X, 0);
        check("memrd_timeout", 32'({mem_timeout, regwrite, memwrite, state}), 32'({1'b1, 1'b0, 1'b0, 4'd3}));
        advance();
        drive(X, 0);
        check("after_timeout", 32'({mem_timeout, irwrite, state}), 32'({1'b0, 1'b0, 4'd0}));
        advance();

        // Same wait, but ready arrives on the 16th cycle.
        drive(X, 1); check("fetch2", 32'({irwrite, state}), 32'({1'b1, 4'd0})); advance();
        drive(6'b100011, 1); advance();
        drive(X, 1);         advance();
        for (int k = 1; k <= 15; k++) begin
            drive(X, 0);
            advance();
        end
        drive(X, 1);
        check("memrd_ready_at_limit", 32'({mem_timeout, state}), 32'({1'b0, 4'd3}));
        advance();
        drive(X, 1);
        check("memwb_after_limit", 32'({regwrite, memtoreg, state}), 32'({1'b1, 1'b1, 4'd4}));
        advance();

        // FETCH also aborts after 16 cycles without ready.
        for (int k = 1; k <= 15; k++) begin
            drive(X, 0);
            advance();
        end
        drive(X, 0);
        check("fetch_timeout", 32'({mem_timeout, irwrite, pcwrite, state}), 32'({1'b1, 1'b0, 1'b0, 4'd0}));
        advance();
        drive(X, 0);
        check("fetch_after_timeout", 32'({mem_timeout, state}), 32'({1'b0, 4'd0}));
        advance();

        // Reset during MEMWR drops memwrite without a clock edge.
        drive(X, 1); advance();
        drive(6'b101011, 1); advance();
        drive(X, 1); advance();
        drive(X, 0);
        check("memwr_before_reset", 32'({memwrite, state}), 32'({1'b1, 4'd5}));
        #2 rst_n = 1'b0;
        #1;
        check("memwr_async_reset", 32'({memwrite, iord, state}), 32'({1'b0, 1'b0, 4'd0}));
        advance();
        @(negedge clk);
        rst_n = 1'b1;
        advance();
        drive(X, 0);
        check("post_reset_idle", 32'(actual_word()), 32'({9'b0, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 4'd0}));
        advance();
        drive(X, 1);
        check("post_reset_fetch", 32'({irwrite, pcwrite, state}), 32'({1'b1, 1'b1, 4'd0}));
        advance();
        check("post_reset_decode", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
